inst_sequencer: RTL

- Upstream feeder for the MPU datapath: a small program buffer plus program counter that replaces hand-entered instructions.
- Buffers up to DEPTH 16-bit instructions, then issues them one at a time on `instruction` with an `inst_valid` strobe.
- Output timing is the one the MPU's register file, mux and ALU consume.
- Supports free-run and single-step (button-driven) execution, abort, and a HALT opcode.

---
 rtl/inst_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
//   Program buffer plus program counter that feeds the MPU datapath. Up to
//   DEPTH 16-bit instructions are loaded through a valid/ready handshake and
//   then issued one at a time on `instruction` with a one-cycle `inst_valid`
//   strobe. Each issue is followed by ISSUE_GAP idle cycles so the MPU register
//   write settles before the next instruction arrives. Execution is free-run or
//   single-step, and stops at the end of the program, on a HALT_OP opcode, or
//   on abort.
//
// Optional build macro:
//   INST_SEQUENCER_STEP_EDGE_EN - when defined, `step` passes through a 2-flop
//   synchroniser and a rising-edge detector (one advance per press). When
//   undefined, each cycle `step` is high in STEP_HOLD is one advance.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   load_valid   in   load handshake valid
//   load_data    in   [15:0] instruction to append
//   load_ready   out  buffer can accept a word (IDLE/DONE, not full, no start)
//   clear        in   empty the buffer (IDLE/DONE only)
//   start        in   begin execution at address 0
//   step_mode    in   1 = single-step, 0 = free-run
//   step         in   step request
//   abort        in   stop execution and return to IDLE
//   instruction  out  [15:0] instruction to the MPU, held between issues
//   inst_valid   out  one-cycle strobe marking a new instruction
//   pc           out  [AW-1:0] address of the current or last issued word
//   count        out  [AW:0] number of loaded words
//   busy         out  high in ISSUE/WAIT/STEP_HOLD
//   done         out  high in DONE
// -----------------------------------------------------------------------------
module inst_sequencer #(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter int         ISSUE_GAP = 2,
  parameter logic [3:0] HALT_OP   = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [15:0]   load_data,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          abort,
  output logic [15:0]   instruction,
  output logic          inst_valid,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_STEP_HOLD = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [3:0]  GAP_LAST = 4'(ISSUE_GAP - 1);

  state_t        state_q, state_d;
  logic [15:0]   instruction_q, instruction_d;
  logic          inst_valid_q, inst_valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    gap_q, gap_d;
  logic [15:0]   mem_q [DEPTH];

  logic          idle_or_done;
  logic          load_fire;
  logic          run_start;
  logic          is_halt;
  logic          gap_last;
  logic          pc_at_end;
  logic          step_evt;

  // ---- step event source ----
`ifdef INST_SEQUENCER_STEP_EDGE_EN
  logic [2:0] step_sync_q, step_sync_d;

  always_comb begin
    step_sync_d = {step_sync_q[1:0], step};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_sync_q <= '0;
    else      step_sync_q <= step_sync_d;
  end

  // Bit 1 is the synchronised level; bit 2 is its previous value.
  assign step_evt = step_sync_q[1] & ~step_sync_q[2];
`else
  assign step_evt = step;
`endif

  // ---- shared decode ----
  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign run_start    = start && (count_q != '0);
  assign is_halt      = (mem_q[pc_q][15:12] == HALT_OP);
  assign gap_last     = (gap_q == GAP_LAST);
  // count_q >= 1 whenever this is consulted (only while running).
  assign pc_at_end    = ({1'b0, pc_q} == (count_q - (AW+1)'(1)));

  // ---- state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (clear)          state_d = S_IDLE;
        else if (run_start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)        state_d = S_IDLE;
        else if (is_halt) state_d = S_DONE;
        else              state_d = S_WAIT;
      end
      S_WAIT: begin
        if (abort)          state_d = S_IDLE;
        else if (gap_last) begin
          if (pc_at_end)      state_d = S_DONE;
          else if (step_mode) state_d = S_STEP_HOLD;
          else                state_d = S_ISSUE;
        end
      end
      S_STEP_HOLD: begin
        if (abort)         state_d = S_IDLE;
        else if (step_evt) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                 (state_q == S_STEP_HOLD);
    done       = (state_q == S_DONE);
    // Gated by rst so the handshake is closed while reset is held.
    load_ready = rst && idle_or_done && (count_q < DEPTH_C) && !start;
    // clear wins over a same-cycle load.
    load_fire  = load_valid && load_ready && !clear;
  end

  // ---- datapath next values ----
  always_comb begin
    instruction_d = instruction_q;
    inst_valid_d  = 1'b0;
    pc_d          = pc_q;
    count_d       = count_q;
    gap_d         = gap_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (clear) begin
          count_d = '0;
          pc_d    = '0;
        end else if (run_start) begin
          pc_d = '0;
        end else if (load_fire) begin
          count_d = count_q + (AW+1)'(1);
        end
      end
      S_ISSUE: begin
        gap_d = '0;
        if (abort) begin
          pc_d = '0;
        end else if (!is_halt) begin
          instruction_d = mem_q[pc_q];
          inst_valid_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (abort) begin
          pc_d = '0;
        end else begin
          gap_d = gap_q + 4'd1;
          if (gap_last && !pc_at_end) pc_d = pc_q + AW'(1);
        end
      end
      S_STEP_HOLD: begin
        if (abort) pc_d = '0;
      end
      default: ;
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_q <= '0;
      inst_valid_q  <= 1'b0;
      pc_q          <= '0;
      count_q       <= '0;
      gap_q         <= '0;
    end else begin
      instruction_q <= instruction_d;
      inst_valid_q  <= inst_valid_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      gap_q         <= gap_d;
    end
  end

  // Program buffer has no reset; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (load_fire) mem_q[count_q[AW-1:0]] <= load_data;
  end

  assign instruction = instruction_q;
  assign inst_valid  = inst_valid_q;
  assign pc          = pc_q;
  assign count       = count_q;

endmodule
